// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity encodings and the default frame width.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_bit_sampler.sv
// Line-side front end of the receiver: synchronizes the serial line, tracks the position
// inside the current bit period and majority-votes three samples around the bit centre.
module rx_bit_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               active,
    input  logic [PRESC_W-1:0] prescale,
    output logic               rx_s,
    output logic               sampled_bit,
    output logic               sample_done,
    output logic               bit_end
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

    logic               sync1;
    logic               sync2;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last_edge;
    logic [2:0]         samples;

    assign half      = prescale >> 1;
    assign last_edge = prescale - ONE;
    assign rx_s      = sync2;

    // Idle-high reset value keeps a reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Held at zero while idle, so every frame begins counting from its start-bit edge.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            edge_cnt <= '0;
        end else if (edge_cnt == last_edge) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samples <= 3'b111;
        end else if (active) begin
            if (edge_cnt == half - ONE) samples[0] <= rx_s;
            if (edge_cnt == half)       samples[1] <= rx_s;
            if (edge_cnt == half + ONE) samples[2] <= rx_s;
        end
    end

    assign sampled_bit = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);
    assign sample_done = active && (edge_cnt == half + TWO);
    assign bit_end     = active && (edge_cnt == last_edge);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: walks start, data, optional parity and stop bits, then emits the
// byte with a one-cycle valid strobe or a parity/stop error strobe.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    rx_state_t             next_state;
    logic [PRESC_W-1:0]    prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_fail;
    logic                  expected_par;
    logic                  active;
    logic                  rx_s;
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  bit_end;

    assign active       = (state != IDLE);
    assign expected_par = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;

    rx_bit_sampler #(
        .PRESC_W(PRESC_W)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .rx_in      (RX_IN),
        .active     (active),
        .prescale   (prescale_q),
        .rx_s       (rx_s),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done),
        .bit_end    (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // STOP leaves at the mid-bit sample so a directly following start bit is not missed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rx_s) next_state = START;
            end
            START: begin
                if (sample_done && sampled_bit) begin
                    next_state = IDLE;
                end else if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (sample_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame configuration is captured only while idle, so mid-frame changes have no effect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_fail   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            case (state)
                IDLE: begin
                    prescale_q <= Prescale;
                    par_en_q   <= PAR_EN;
                    par_typ_q  <= PAR_TYP;
                    bit_cnt    <= '0;
                    par_fail   <= 1'b0;
                end
                DATA: begin
                    if (sample_done) shift[bit_cnt] <= sampled_bit;
                    if (bit_end && (bit_cnt != LAST_BIT)) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                PARITY: begin
                    if (sample_done && (sampled_bit != expected_par)) par_fail <= 1'b1;
                end
                STOP: begin
                    if (sample_done) begin
                        if (!sampled_bit) begin
                            Stp_Err <= 1'b1;
                            Par_Err <= par_fail;
                        end else if (par_fail) begin
                            Par_Err <= 1'b1;
                        end else begin
                            Data_Valid <= 1'b1;
                            P_DATA     <= shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
